// File: rtl/pipe_pkg.sv
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared constants and the pipeline control slice for hazard_pipe_regs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_EX  = 2'd2;

  typedef struct packed {
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
    logic       frd;
    logic       valid;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '{rd: 5'd0, regwrite: 1'b0, memread: 1'b0,
                                    frd: 1'b0, valid: 1'b0};

endpackage

`default_nettype wire

// File: rtl/pipe_fwd_mux.sv
// ============================================================================
// Module : pipe_fwd_mux
// Brief  : Operand bypass select; the reserved encoding falls back to the regfile.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_fwd_mux
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      sel,
  input  logic [XLEN-1:0] rf,
  input  logic [XLEN-1:0] mem,
  input  logic [XLEN-1:0] ex,
  output logic [XLEN-1:0] op
);

  always_comb begin
    op = rf;
    case (sel)
      FWD_MEM: op = mem;
      FWD_EX:  op = ex;
      default: op = rf;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/hazard_pipe_regs.sv
// ============================================================================
// Module : hazard_pipe_regs
// Brief  : IF/ID, ID/EX and EX/MEM registers with stall/branch bubbling,
//          operand bypass, event counters and a sticky protocol error flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_pipe_regs
  import pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [31:0]      if_instr,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_frd,
  input  logic [XLEN-1:0]  id_rs1_val,
  input  logic [XLEN-1:0]  id_rs2_val,
  input  logic             stall,
  input  logic             flush,
  input  logic             branch_taken,
  input  logic [1:0]       rs1_fwd,
  input  logic [1:0]       rs2_fwd,
  input  logic [XLEN-1:0]  ex_result,
  input  logic [XLEN-1:0]  mem_result,
  output logic [XLEN-1:0]  id_pc,
  output logic [31:0]      id_instr,
  output logic             id_valid,
  output logic [4:0]       ex_rd,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_frd,
  output logic             ex_valid,
  output logic [4:0]       mem_rd,
  output logic             mem_regwrite,
  output logic             mem_frd,
  output logic             mem_valid,
  output logic [XLEN-1:0]  id_op1,
  output logic [XLEN-1:0]  id_op2,
  output logic [XLEN-1:0]  ex_op1,
  output logic [XLEN-1:0]  ex_op2,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             stall_err
);

  logic [XLEN-1:0]  r_id_pc;
  logic [31:0]      r_id_instr;
  logic             r_id_valid;
  ctrl_t            r_ex_ctrl;
  logic [XLEN-1:0]  r_ex_op1;
  logic [XLEN-1:0]  r_ex_op2;
  ctrl_t            r_mem_ctrl;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             r_stall_err;
  logic             r_stall_q;
  logic [XLEN-1:0]  w_op1;
  logic [XLEN-1:0]  w_op2;
  logic             w_bubble;
  logic             w_proto_err;

  pipe_fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
    .sel(rs1_fwd), .rf(id_rs1_val), .mem(mem_result), .ex(ex_result), .op(w_op1)
  );

  pipe_fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
    .sel(rs2_fwd), .rf(id_rs2_val), .mem(mem_result), .ex(ex_result), .op(w_op2)
  );

  assign w_bubble = branch_taken | stall;
  // A load-use stall is exactly one bubble; flush without a cause is a protocol slip.
  assign w_proto_err = (stall & r_stall_q) | (flush & ~stall & ~branch_taken);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_pc     <= '0;
      r_id_instr  <= NOP_INSTR;
      r_id_valid  <= 1'b0;
      r_ex_ctrl   <= BUBBLE_CTRL;
      r_ex_op1    <= '0;
      r_ex_op2    <= '0;
      r_mem_ctrl  <= BUBBLE_CTRL;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_stall_err <= 1'b0;
      r_stall_q   <= 1'b0;
    end else begin
      if (branch_taken) begin
        r_id_pc    <= '0;
        r_id_instr <= NOP_INSTR;
        r_id_valid <= 1'b0;
      end else if (!stall) begin
        r_id_pc    <= if_pc;
        r_id_instr <= if_instr;
        r_id_valid <= 1'b1;
      end

      if (w_bubble) begin
        r_ex_ctrl <= BUBBLE_CTRL;
        r_ex_op1  <= '0;
        r_ex_op2  <= '0;
      end else begin
        r_ex_ctrl <= '{rd: id_rd, regwrite: id_regwrite, memread: id_memread,
                       frd: id_frd, valid: r_id_valid};
        r_ex_op1  <= w_op1;
        r_ex_op2  <= w_op2;
      end

      r_mem_ctrl <= r_ex_ctrl;

      if (stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (branch_taken && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end

      r_stall_q <= stall;
      if (w_proto_err) begin
        r_stall_err <= 1'b1;
      end
    end
  end

  assign id_pc        = r_id_pc;
  assign id_instr     = r_id_instr;
  assign id_valid     = r_id_valid;
  assign ex_rd        = r_ex_ctrl.rd;
  assign ex_regwrite  = r_ex_ctrl.regwrite;
  assign ex_memread   = r_ex_ctrl.memread;
  assign ex_frd       = r_ex_ctrl.frd;
  assign ex_valid     = r_ex_ctrl.valid;
  assign mem_rd       = r_mem_ctrl.rd;
  assign mem_regwrite = r_mem_ctrl.regwrite;
  assign mem_frd      = r_mem_ctrl.frd;
  assign mem_valid    = r_mem_ctrl.valid;
  assign id_op1       = w_op1;
  assign id_op2       = w_op2;
  assign ex_op1       = r_ex_op1;
  assign ex_op2       = r_ex_op2;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;
  assign stall_err    = r_stall_err;

  // The memread bit has no consumer past EX.
  logic w_unused;
  assign w_unused = r_mem_ctrl.memread;

endmodule

`default_nettype wire

// File: tb/tb_hazard_pipe_regs.sv
// ============================================================================
// Module : tb_hazard_pipe_regs
// Brief  : Scoreboard bench for hazard_pipe_regs: expected values are queued
//          with the stimulus and popped when the DUT output is sampled.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_pipe_regs;

  localparam int XLEN  = 32;
  localparam int CNT_W = 16;
  localparam logic [31:0] C_NOP = 32'h0000_0013;

  logic             clk;
  logic             rst;
  logic [XLEN-1:0]  if_pc;
  logic [31:0]      if_instr;
  logic [4:0]       id_rd;
  logic             id_regwrite, id_memread, id_frd;
  logic [XLEN-1:0]  id_rs1_val, id_rs2_val;
  logic             stall, flush, branch_taken;
  logic [1:0]       rs1_fwd, rs2_fwd;
  logic [XLEN-1:0]  ex_result, mem_result;
  logic [XLEN-1:0]  id_pc;
  logic [31:0]      id_instr;
  logic             id_valid;
  logic [4:0]       ex_rd;
  logic             ex_regwrite, ex_memread, ex_frd, ex_valid;
  logic [4:0]       mem_rd;
  logic             mem_regwrite, mem_frd, mem_valid;
  logic [XLEN-1:0]  id_op1, id_op2, ex_op1, ex_op2;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             stall_err;

  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  hazard_pipe_regs #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_instr(if_instr),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .id_frd(id_frd),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
    .stall(stall), .flush(flush), .branch_taken(branch_taken),
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .ex_result(ex_result), .mem_result(mem_result),
    .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_frd(ex_frd),
    .ex_valid(ex_valid), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_frd(mem_frd),
    .mem_valid(mem_valid), .id_op1(id_op1), .id_op2(id_op2), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .stall_err(stall_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    if_pc = '0; if_instr = C_NOP;
    id_rd = '0; id_regwrite = 0; id_memread = 0; id_frd = 0;
    id_rs1_val = '0; id_rs2_val = '0;
    stall = 0; flush = 0; branch_taken = 0;
    rs1_fwd = 2'd0; rs2_fwd = 2'd0;
    ex_result = '0; mem_result = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1;
    if_instr = 32'hDEAD_BEEF; if_pc = 32'h40;
    exp_q.push_back(C_NOP); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    tick();
    rst = 0;
    e = exp_q.pop_front(); n_vec++;
    if (id_instr !== e) begin n_fail++; $display("FAIL reset_instr: got %h want %h", id_instr, e); end
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, id_valid} !== e) begin n_fail++; $display("FAIL reset_id_valid: got %0d want %0d", id_valid, e); end
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, ex_valid} !== e) begin n_fail++; $display("FAIL reset_ex_valid: got %0d want %0d", ex_valid, e); end
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, mem_valid} !== e) begin n_fail++; $display("FAIL reset_mem_valid: got %0d want %0d", mem_valid, e); end
    e = exp_q.pop_front(); n_vec++;
    if ({16'd0, stall_cnt} !== e) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d want %0d", stall_cnt, e); end
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, stall_err} !== e) begin n_fail++; $display("FAIL reset_err: got %0d want %0d", stall_err, e); end
  endtask

  task automatic test_forward;
    do_reset();
    if_pc = 32'h100; if_instr = 32'h0050_0293;
    exp_q.push_back(32'h100); exp_q.push_back(32'h0050_0293);
    tick();
    e = exp_q.pop_front(); n_vec++;
    if (id_pc !== e) begin n_fail++; $display("FAIL fwd_id_pc: got %h want %h", id_pc, e); end
    e = exp_q.pop_front(); n_vec++;
    if (id_instr !== e) begin n_fail++; $display("FAIL fwd_id_instr: got %h want %h", id_instr, e); end
    // addi x5 in decode
    id_rd = 5'd5; id_regwrite = 1; id_rs1_val = 32'h7;
    if_pc = 32'h104; if_instr = 32'h0012_8333;
    exp_q.push_back(32'd5); exp_q.push_back(32'h7);
    tick();
    e = exp_q.pop_front(); n_vec++;
    if ({27'd0, ex_rd} !== e || ex_valid !== 1'b1) begin n_fail++; $display("FAIL fwd_ex_rd: got %0d/v%0d want %0d/v1", ex_rd, ex_valid, e); end
    e = exp_q.pop_front(); n_vec++;
    if (ex_op1 !== e) begin n_fail++; $display("FAIL fwd_ex_op1_rf: got %h want %h", ex_op1, e); end
    // add x6,x5,x1 needs x5 from EX
    id_rd = 5'd6; rs1_fwd = 2'd2; ex_result = 32'h2A; id_rs1_val = 32'h99; id_rs2_val = 32'h3;
    exp_q.push_back(32'h2A); exp_q.push_back(32'h3);
    #1;
    e = exp_q.pop_front(); n_vec++;
    if (id_op1 !== e) begin n_fail++; $display("FAIL fwd_id_op1: got %h want %h", id_op1, e); end
    e = exp_q.pop_front(); n_vec++;
    if (id_op2 !== e) begin n_fail++; $display("FAIL fwd_id_op2: got %h want %h", id_op2, e); end
    exp_q.push_back(32'h2A); exp_q.push_back(32'd5);
    tick();
    rs1_fwd = 2'd0;
    e = exp_q.pop_front(); n_vec++;
    if (ex_op1 !== e) begin n_fail++; $display("FAIL fwd_ex_op1: got %h want %h", ex_op1, e); end
    e = exp_q.pop_front(); n_vec++;
    if ({27'd0, mem_rd} !== e || mem_valid !== 1'b1) begin n_fail++; $display("FAIL fwd_mem_rd: got %0d/v%0d want %0d/v1", mem_rd, mem_valid, e); end
  endtask

  task automatic test_fwd_selects;
    logic [31:0] exp1 [4];
    logic [31:0] exp2 [4];
    exp1 = '{32'h11, 32'h22, 32'h33, 32'h11};
    exp2 = '{32'h44, 32'h22, 32'h33, 32'h44};
    id_rs1_val = 32'h11; id_rs2_val = 32'h44; mem_result = 32'h22; ex_result = 32'h33;
    for (int s = 0; s < 4; s++) begin
      rs1_fwd = s[1:0]; rs2_fwd = 2'(3 - s);
      exp_q.push_back(exp1[s]); exp_q.push_back(exp2[3 - s]);
      #1;
      e = exp_q.pop_front(); n_vec++;
      if (id_op1 !== e) begin n_fail++; $display("FAIL sel_op1[%0d]: got %h want %h", s, id_op1, e); end
      e = exp_q.pop_front(); n_vec++;
      if (id_op2 !== e) begin n_fail++; $display("FAIL sel_op2[%0d]: got %h want %h", 3 - s, id_op2, e); end
    end
    idle_inputs();
  endtask

  task automatic test_load_use;
    do_reset();
    if_instr = 32'h0000_A283;
    tick();
    id_rd = 5'd5; id_regwrite = 1; id_memread = 1; if_instr = 32'h0012_8333;
    exp_q.push_back(32'd1); exp_q.push_back(32'h0012_8333);
    tick();
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, ex_memread} !== e || ex_valid !== 1'b1) begin n_fail++; $display("FAIL lu_ex_load: got m%0d/v%0d want m1/v1", ex_memread, ex_valid); end
    e = exp_q.pop_front(); n_vec++;
    if (id_instr !== e) begin n_fail++; $display("FAIL lu_id_instr: got %h want %h", id_instr, e); end
    // dependent add decoded: one-cycle stall
    id_rd = 5'd6; id_memread = 0; stall = 1; flush = 1; if_instr = 32'h0000_0533;
    exp_q.push_back(32'h0012_8333); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    tick();
    stall = 0; flush = 0;
    e = exp_q.pop_front(); n_vec++;
    if (id_instr !== e) begin n_fail++; $display("FAIL lu_hold: got %h want %h", id_instr, e); end
    e = exp_q.pop_front(); n_vec++;
    if ({30'd0, ex_valid, ex_regwrite} !== e) begin n_fail++; $display("FAIL lu_bubble: got v%0d/w%0d want v0/w0", ex_valid, ex_regwrite); end
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, mem_valid} !== e) begin n_fail++; $display("FAIL lu_mem_valid: got %0d want %0d", mem_valid, e); end
    e = exp_q.pop_front(); n_vec++;
    if ({16'd0, stall_cnt} !== e) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d want %0d", stall_cnt, e); end
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, stall_err} !== e) begin n_fail++; $display("FAIL lu_err: got %0d want %0d", stall_err, e); end
    exp_q.push_back(32'd6); exp_q.push_back(32'h0000_0533);
    tick();
    e = exp_q.pop_front(); n_vec++;
    if ({27'd0, ex_rd} !== e || ex_valid !== 1'b1) begin n_fail++; $display("FAIL lu_resume: got rd%0d/v%0d want rd%0d/v1", ex_rd, ex_valid, e); end
    e = exp_q.pop_front(); n_vec++;
    if (id_instr !== e) begin n_fail++; $display("FAIL lu_next: got %h want %h", id_instr, e); end
  endtask

  task automatic test_branch;
    do_reset();
    if_pc = 32'h200; if_instr = 32'h00A0_0093;
    tick();
    id_rd = 5'd1; id_regwrite = 1;
    branch_taken = 1; stall = 1; flush = 1; if_instr = 32'h0000_0533;
    exp_q.push_back(C_NOP); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    tick();
    branch_taken = 0; stall = 0; flush = 0;
    e = exp_q.pop_front(); n_vec++;
    if (id_instr !== e) begin n_fail++; $display("FAIL br_instr: got %h want %h", id_instr, e); end
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, id_valid} !== e || id_pc !== 32'd0) begin n_fail++; $display("FAIL br_id: got v%0d pc %h want v0 pc 0", id_valid, id_pc); end
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, ex_valid} !== e) begin n_fail++; $display("FAIL br_ex_valid: got %0d want %0d", ex_valid, e); end
    e = exp_q.pop_front(); n_vec++;
    if ({16'd0, flush_cnt} !== e) begin n_fail++; $display("FAIL br_flush_cnt: got %0d want %0d", flush_cnt, e); end
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, stall_err} !== e) begin n_fail++; $display("FAIL br_err: got %0d want %0d", stall_err, e); end
  endtask

  task automatic test_stall_err;
    do_reset();
    stall = 1; flush = 1;
    exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd1);
    tick();
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, stall_err} !== e) begin n_fail++; $display("FAIL err_first: got %0d want %0d", stall_err, e); end
    tick();
    stall = 0; flush = 0;
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, stall_err} !== e) begin n_fail++; $display("FAIL err_second: got %0d want %0d", stall_err, e); end
    tick(); tick();
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, stall_err} !== e) begin n_fail++; $display("FAIL err_sticky: got %0d want %0d", stall_err, e); end
    // flush alone must not bubble but is flagged
    do_reset();
    if_instr = 32'h0010_0093;
    tick();
    flush = 1; id_rd = 5'd3; id_regwrite = 1; if_instr = 32'h0020_0113;
    exp_q.push_back(32'd1); exp_q.push_back(32'h0020_0113); exp_q.push_back(32'd1);
    tick();
    flush = 0;
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, ex_valid} !== e || ex_rd !== 5'd3) begin n_fail++; $display("FAIL fl_no_bubble: got v%0d rd%0d want v1 rd3", ex_valid, ex_rd); end
    e = exp_q.pop_front(); n_vec++;
    if (id_instr !== e) begin n_fail++; $display("FAIL fl_advance: got %h want %h", id_instr, e); end
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, stall_err} !== e) begin n_fail++; $display("FAIL fl_err: got %0d want %0d", stall_err, e); end
  endtask

  task automatic test_saturate;
    do_reset();
    stall = 1;
    for (int i = 0; i < 65534; i++) tick();
    stall = 0;
    exp_q.push_back(32'hFFFE);
    tick();
    e = exp_q.pop_front(); n_vec++;
    if ({16'd0, stall_cnt} !== e) begin n_fail++; $display("FAIL sat_preload: got %h want %h", stall_cnt, e); end
    for (int p = 0; p < 3; p++) begin
      stall = 1; tick();
      stall = 0; tick();
    end
    exp_q.push_back(32'hFFFF);
    e = exp_q.pop_front(); n_vec++;
    if ({16'd0, stall_cnt} !== e) begin n_fail++; $display("FAIL sat_hold: got %h want %h", stall_cnt, e); end
  endtask

  task automatic test_reset_mid_stall;
    do_reset();
    if_instr = 32'h0000_A283; tick();
    id_regwrite = 1; id_rd = 5'd5; if_instr = 32'h0012_8333; tick();
    stall = 1; branch_taken = 1; tick();
    branch_taken = 0; if_instr = 32'h0000_0533; tick();
    stall = 1; rst = 1;
    exp_q.push_back(C_NOP); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    tick();
    rst = 0; stall = 0;
    e = exp_q.pop_front(); n_vec++;
    if (id_instr !== e) begin n_fail++; $display("FAIL rs_instr: got %h want %h", id_instr, e); end
    e = exp_q.pop_front(); n_vec++;
    if ({29'd0, id_valid, ex_valid, mem_valid} !== e) begin n_fail++; $display("FAIL rs_valids: got %b%b%b want 000", id_valid, ex_valid, mem_valid); end
    e = exp_q.pop_front(); n_vec++;
    if ({stall_cnt, flush_cnt} !== e || stall_err !== 1'b0) begin n_fail++; $display("FAIL rs_counters: got s%0d f%0d e%0d want 0 0 0", stall_cnt, flush_cnt, stall_err); end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_forward();
    test_fwd_selects();
    test_load_use();
    test_branch();
    test_stall_err();
    test_reset_mid_stall();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
